// File: rtl/amx_pkg.sv
// Shared types and helpers for the amx dot-product core.
// Holds the FSM state encoding and word-count arithmetic.
package amx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GET_A,
        GET_B,
        EMIT
    } state_t;

    function automatic int ceil_div(input int x, input int y);
        return (x + y - 1) / y;
    endfunction

endpackage

// File: rtl/amx_mac_unit.sv
// Combinational multiply-accumulate step with overflow detection.
// Products and sums are extended one bit past ACC_W to expose overflow.
module amx_mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  acc,
    input  logic              mode,
    output logic [ACC_W-1:0]  acc_next,
    output logic              ovf
);

    localparam int PW = 2 * DATA_W;
    localparam int XW = ACC_W + 1 - PW;

    logic [PW-1:0]  sa, sb;
    logic [PW-1:0]  p_u, p_s, p;
    logic [ACC_W:0] p_ext, acc_ext, sum;

    // Low PW bits of the sign-extended product are the two's-complement result
    assign sa    = {{DATA_W{a[DATA_W-1]}}, a};
    assign sb    = {{DATA_W{b[DATA_W-1]}}, b};
    assign p_s   = sa * sb;
    assign p_u   = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    assign p     = mode ? p_s : p_u;

    assign p_ext   = {{XW{mode & p[PW-1]}}, p};
    assign acc_ext = {mode & acc[ACC_W-1], acc};
    assign sum     = acc_ext + p_ext;

    assign acc_next = sum[ACC_W-1:0];
    assign ovf      = sum[ACC_W] != (mode & sum[ACC_W-1]);

endmodule

// File: rtl/amx_core2.sv
// Streaming dot-product engine: loads LEN (a, b) pairs over ready/valid,
// accumulates sum(a*b), then streams the result LSB word first.
module amx_core2
    import amx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEN    = 4,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode_signed,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overflow
);

    localparam int OUT_WORDS = ceil_div(ACC_W, DATA_W);
    localparam int WI_W      = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
    localparam int PAD_W     = OUT_WORDS * DATA_W;
    localparam logic [7:0]      LAST_PAIR = 8'(LEN - 1);
    localparam logic [WI_W-1:0] LAST_WORD = WI_W'(OUT_WORDS - 1);

    state_t            state, state_n;
    logic [ACC_W-1:0]  acc, acc_next;
    logic [7:0]        pair_cnt;
    logic [WI_W-1:0]   word_idx;
    logic [DATA_W-1:0] a_reg;
    logic              mode;
    logic              ovf;
    logic [PAD_W-1:0]  acc_pad;
    logic [DATA_W-1:0] words [OUT_WORDS];

    amx_mac_unit #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .a       (a_reg),
        .b       (in_data),
        .acc     (acc),
        .mode    (mode),
        .acc_next(acc_next),
        .ovf     (ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = GET_A;
            end
            GET_A: begin
                in_ready = 1'b1;
                if (in_valid) state_n = GET_B;
            end
            GET_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_n = (pair_cnt == LAST_PAIR) ? EMIT : GET_A;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready && word_idx == LAST_WORD) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            pair_cnt <= '0;
            word_idx <= '0;
            a_reg    <= '0;
            mode     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                mode     <= mode_signed;
                acc      <= '0;
                overflow <= 1'b0;
                pair_cnt <= '0;
                word_idx <= '0;
            end
            if (state == GET_A && in_valid) begin
                a_reg <= in_data;
            end
            if (state == GET_B && in_valid) begin
                acc      <= acc_next;
                overflow <= overflow | ovf;
                pair_cnt <= pair_cnt + 8'd1;
            end
            if (state == EMIT && out_ready) begin
                word_idx <= (word_idx == LAST_WORD) ? '0 : word_idx + 1'b1;
            end
        end
    end

    // Top word is zero-padded when ACC_W is not a multiple of DATA_W
    assign acc_pad = PAD_W'(acc);

    always_comb begin
        for (int i = 0; i < OUT_WORDS; i++) begin
            words[i] = acc_pad[i*DATA_W +: DATA_W];
        end
    end

    assign out_data = (state == EMIT) ? words[word_idx] : '0;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_amx_core2.sv
// Directed bench for amx_core2: table of dot-product vectors over a
// 24-bit and a 16-bit accumulator instance, plus multi-cycle sequences.
module tb_amx_core2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic       mode_signed = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready0, in_ready1;
    logic [7:0] out_data0, out_data1;
    logic       out_valid0, out_valid1;
    logic       busy0, busy1;
    logic       ovf0, ovf1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    amx_core2 u0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .mode_signed(mode_signed), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0),
        .out_ready(out_ready), .busy(busy0), .overflow(ovf0)
    );

    amx_core2 #(.ACC_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .mode_signed(mode_signed), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready), .busy(busy1), .overflow(ovf1)
    );

    typedef struct {
        bit          sel;
        bit          mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [23:0] res;
        bit          ovf;
    } vec_t;

    vec_t vecs[8];

    function automatic logic f_rdy(input bit s);
        return s ? in_ready1 : in_ready0;
    endfunction
    function automatic logic f_ov(input bit s);
        return s ? out_valid1 : out_valid0;
    endfunction
    function automatic logic [7:0] f_od(input bit s);
        return s ? out_data1 : out_data0;
    endfunction
    function automatic logic f_busy(input bit s);
        return s ? busy1 : busy0;
    endfunction
    function automatic logic f_ovf(input bit s);
        return s ? ovf1 : ovf0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic expired(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got timeout want handshake", nm);
    endtask

    task automatic do_start(input bit s, input bit m);
        start0 = !s;
        start1 = s;
        mode_signed = m;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic send(input bit s, input logic [7:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data = d;
        while (!f_rdy(s) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) expired("send");
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'hA5;
    endtask

    task automatic feed(input bit s, input logic [31:0] a,
                        input logic [31:0] b, input int gap);
        for (int i = 0; i < 4; i++) begin
            send(s, a[i*8 +: 8]);
            repeat (gap) @(negedge clk);
            send(s, b[i*8 +: 8]);
        end
    endtask

    task automatic collect(input bit s, input int stall,
                           output logic [23:0] res);
        int nw = s ? 2 : 3;
        int n;
        logic [7:0] d;
        bit stable;
        res = '0;
        out_ready = 1'b1;
        for (int w = 0; w < nw; w++) begin
            n = 0;
            while (!f_ov(s) && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) begin
                expired("collect");
                return;
            end
            d = f_od(s);
            if (w == 0 && stall > 0) begin
                out_ready = 1'b0;
                stable = 1'b1;
                for (int k = 0; k < stall; k++) begin
                    @(negedge clk);
                    if (!f_ov(s) || f_od(s) !== d) stable = 1'b0;
                end
                chk("hold_stable", 32'(stable), 32'd1);
                out_ready = 1'b1;
            end
            res[w*8 +: 8] = d;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] res;

        vecs[0] = '{0, 0, 32'h04030201, 32'h08070605, 24'h000046, 0};
        vecs[1] = '{0, 1, 32'h000000FE, 32'h00000003, 24'hFFFFFA, 0};
        vecs[2] = '{1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 24'h00F804, 1};
        vecs[3] = '{0, 1, 32'h80808080, 32'h80808080, 24'h010000, 0};
        vecs[4] = '{1, 1, 32'h80808080, 32'h80808080, 24'h000000, 1};
        vecs[5] = '{0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 24'h03F804, 0};
        vecs[6] = '{1, 1, 32'hFFFFFFFF, 32'h01010101, 24'h00FFFC, 0};
        vecs[7] = '{0, 1, 32'h7F7F7F7F, 32'h81818181, 24'hFF03FC, 0};

        #3 rst_n = 1'b0;
        #2;
        chk("reset_u0", {busy0, in_ready0, out_valid0, ovf0, out_data0}, 0);
        chk("reset_u1", {busy1, in_ready1, out_valid1, ovf1, out_data1}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_start(vecs[i].sel, vecs[i].mode);
            feed(vecs[i].sel, vecs[i].a, vecs[i].b, 0);
            chk($sformatf("latency_%0d", i), 32'(f_ov(vecs[i].sel)), 1);
            collect(vecs[i].sel, 0, res);
            chk($sformatf("result_%0d", i), 32'(res), 32'(vecs[i].res));
            chk($sformatf("busy_drop_%0d", i), 32'(f_busy(vecs[i].sel)), 0);
            chk($sformatf("overflow_%0d", i), 32'(f_ovf(vecs[i].sel)),
                32'(vecs[i].ovf));
        end

        // Input gaps and output backpressure
        do_start(0, 0);
        feed(0, 32'h04030201, 32'h08070605, 2);
        collect(0, 5, res);
        chk("gap_stall_result", 32'(res), 32'h46);

        // start while busy in GET_B and in EMIT
        do_start(0, 0);
        send(0, 8'h01);
        start0 = 1'b1;
        mode_signed = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        send(0, 8'h05);
        send(0, 8'h02); send(0, 8'h06);
        send(0, 8'h03); send(0, 8'h07);
        send(0, 8'h04); send(0, 8'h08);
        chk("emit_reached", 32'(out_valid0), 1);
        out_ready = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        collect(0, 0, res);
        chk("start_ignored_result", 32'(res), 32'h46);
        chk("start_ignored_idle", 32'(busy0), 0);

        // Sticky overflow persists in IDLE, clears on next start
        do_start(1, 0);
        feed(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        collect(1, 0, res);
        repeat (3) @(negedge clk);
        chk("ovf_held_idle", 32'(ovf1), 1);
        do_start(1, 0);
        chk("ovf_clear_on_start", 32'(ovf1), 0);
        feed(1, 32'h04030201, 32'h08070605, 0);
        collect(1, 0, res);
        chk("after_ovf_result", 32'(res), 32'h46);
        chk("after_ovf_flag", 32'(ovf1), 0);

        // Asynchronous reset mid-load, then a clean run
        do_start(0, 0);
        send(0, 8'h09); send(0, 8'h09);
        send(0, 8'h09); send(0, 8'h09);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {busy0, in_ready0, out_valid0, ovf0, out_data0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(0, 0);
        feed(0, 32'h04030201, 32'h08070605, 0);
        collect(0, 0, res);
        chk("post_reset_result", 32'(res), 32'h46);
        chk("post_reset_ovf", 32'(ovf0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/amx_core2.md
Name: amx_core2

Overview:
Parametrised successor of the first-generation byte-stream core. It is a streaming dot-product engine: after a start pulse it accepts LEN operand pairs (a, b) one word at a time over a DATA_W-bit ready/valid input. It accumulates sum(a*b) in an ACC_W-bit register, in signed or unsigned mode, then streams the result out LSB-word first over a ready/valid output. It sits behind the tt_um_ top wrapper, which maps ui_in/uo_out/uio onto its ports.

Parameters:
DATA_W, 8, operand and I/O word width in bits
LEN, 4, number of (a, b) pairs per dot product; legal range 1..255
ACC_W, 24, accumulator width in bits; must be >= 2*DATA_W
OUT_WORDS, ceil(ACC_W/DATA_W), derived localparam; words emitted per result

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
start  in  1  one-cycle pulse; begins an operation; honoured only in IDLE
mode_signed  in  1  sampled with start; 1 = two's-complement operands, 0 = unsigned
in_data  in  DATA_W  operand word
in_valid  in  1  in_data valid
in_ready  out  1  core accepts in_data this cycle
out_data  out  DATA_W  result word
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts out_data
busy  out  1  high in any state other than IDLE
overflow  out  1  sticky; set if the true sum does not fit in ACC_W for the latched mode

Behaviour:
- Reset (async assert, sync deassert handled externally): state=IDLE, acc=0, pair_cnt=0, word_idx=0, a_reg=0, mode=0. All outputs are 0, including overflow.
- FSM states: IDLE, GET_A, GET_B, EMIT.
- IDLE, start=1: latch mode_signed, clear acc, overflow, pair_cnt and word_idx; go to GET_A next cycle.
- start in any other state is ignored and has no effect.
- GET_A: in_ready=1. On in_valid, latch a_reg=in_data and go to GET_B.
- GET_B: in_ready=1. On in_valid, form product p = a_reg*in_data (2*DATA_W bits).
  - Extend p to ACC_W+1 bits: sign-extended if mode=1, zero-extended otherwise.
  - acc <= acc + p, truncated to ACC_W bits.
  - overflow is set if the ACC_W+1-bit sum differs from the sign/zero extension of its low ACC_W bits.
  - pair_cnt increments. If pair_cnt was LEN-1, go to EMIT; otherwise go to GET_A.
- Input latency: one accepted word per cycle maximum. A pair costs 2 cycles with in_valid held high.
- EMIT: out_valid=1 and out_data = acc[word_idx*DATA_W +: DATA_W]. The top word is padded with zeros if ACC_W is not a multiple of DATA_W.
  - On out_ready, word_idx increments. After word OUT_WORDS-1 is accepted, go to IDLE; busy drops the following cycle.
  - While out_valid=1 and out_ready=0, out_data is held stable.
- in_ready=0 in IDLE and EMIT. in_data is ignored whenever in_ready=0.
- out_valid=0 outside EMIT.
- overflow holds its value through EMIT and into IDLE. It clears only on the next accepted start or on reset.
- The first result word is available the cycle after the final b is accepted.
- Reset mid-operation aborts immediately: partial acc is discarded and no output is produced.

Decomposition:
- Shared package amx_pkg: state enum type (IDLE/GET_A/GET_B/EMIT) and function ceil_div(x, y) used for OUT_WORDS.
- One sub-module, amx_mac_unit: combinational. Inputs a, b, acc and mode. Outputs acc_next (ACC_W bits) and ovf (1 bit).
- The FSM, counters and output mux stay in amx_core2.

Test Plan:
- Unsigned, defaults, a=1,2,3,4 with b=5,6,7,8, sink always ready -> out words 0x46, 0x00, 0x00; overflow=0; busy low after 3rd word.
- Signed, defaults, pairs (0xFE,0x03), (0,0), (0,0), (0,0) -> out words 0xFA, 0xFF, 0xFF (-6); overflow=0.
- ACC_W=16, unsigned, four pairs (0xFF,0xFF) -> out words 0x04, 0xF8 (260100 mod 65536); overflow=1, held in IDLE until next start.
- Backpressure: hold out_ready=0 for 5 cycles in EMIT -> out_valid=1 and out_data=0x46 stable throughout. Gaps in in_valid during load must not change the result.
- start pulsed while busy in GET_B and in EMIT -> no restart; result of the original operation is unchanged.
- Assert rst_n=0 mid-load after 2 pairs -> outputs 0 immediately (async). A fresh run afterwards gives the correct result with no residue.
